// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : fetch sequencer states
//   NOP_INSTR     : instruction presented on if_instr after reset
//   PC_STEP       : sequential PC increment in bytes
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer and instruction-memory port for the
// fetch stage. Keeps at most one memory request outstanding, presents
// instr/pc pairs to decode under stall backpressure, and absorbs redirects
// from execute by dropping in-flight and buffered fetches.
//
// Ports:
//   clk, rstn              clock (rising edge), async active-low reset
//   redirect_valid/_pc     branch/jump redirect; _pc[1:0] ignored
//   stall                  decode cannot accept; output holds
//   imem_req/_addr         fetch request and address
//   imem_gnt               request accepted this cycle
//   imem_rvalid/_rdata     read response (>= 1 cycle after gnt)
//   if_valid/_pc/_instr    instruction beat towards decode
//   perf_fetch_cnt         (FETCH_PERF_CNT_EN) consumed output beats
//   perf_flush_cnt         (FETCH_PERF_CNT_EN) redirects that discarded work
//
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned            WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  redirect_valid,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [WORD_WIDTH-1:0] if_pc,
  output logic [WORD_WIDTH-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  fetch_state_t          r_state,     w_nxt_state;
  logic [WORD_WIDTH-1:0] r_pc,        w_nxt_pc;
  logic [WORD_WIDTH-1:0] r_req_pc,    w_nxt_req_pc;
  logic                  r_if_valid,  w_nxt_if_valid;
  logic [WORD_WIDTH-1:0] r_if_pc,     w_nxt_if_pc;
  logic [WORD_WIDTH-1:0] r_if_instr,  w_nxt_if_instr;
  logic                  r_hold_valid, w_nxt_hold_valid;
  logic [WORD_WIDTH-1:0] r_hold_pc,   w_nxt_hold_pc;
  logic [WORD_WIDTH-1:0] r_hold_instr, w_nxt_hold_instr;

  logic                  w_consume;
  logic [WORD_WIDTH-1:0] w_pc_inc;
  logic [WORD_WIDTH-1:0] w_redir_pc;
  logic                  w_unused_redir_lsb;

  assign w_consume          = r_if_valid & ~stall;
  assign w_pc_inc           = r_pc + WORD_WIDTH'(PC_STEP);
  assign w_redir_pc         = {redirect_pc[WORD_WIDTH-1:2], 2'b00};
  assign w_unused_redir_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= WORD_WIDTH'(NOP_INSTR);
      r_hold_valid <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= WORD_WIDTH'(NOP_INSTR);
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_req_pc     <= w_nxt_req_pc;
      r_if_valid   <= w_nxt_if_valid;
      r_if_pc      <= w_nxt_if_pc;
      r_if_instr   <= w_nxt_if_instr;
      r_hold_valid <= w_nxt_hold_valid;
      r_hold_pc    <= w_nxt_hold_pc;
      r_hold_instr <= w_nxt_hold_instr;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_req_pc     = r_req_pc;
    // A consumed beat disappears unless something below replaces it.
    w_nxt_if_valid   = r_if_valid & ~w_consume;
    w_nxt_if_pc      = r_if_pc;
    w_nxt_if_instr   = r_if_instr;
    w_nxt_hold_valid = r_hold_valid;
    w_nxt_hold_pc    = r_hold_pc;
    w_nxt_hold_instr = r_hold_instr;
    imem_req         = 1'b0;

    case (r_state)
      IDLE: w_nxt_state = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          w_nxt_req_pc = r_pc;
          w_nxt_state  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_nxt_pc = w_pc_inc;
          if (!r_if_valid || !stall) begin
            w_nxt_if_valid = 1'b1;
            w_nxt_if_pc    = r_req_pc;
            w_nxt_if_instr = imem_rdata;
            w_nxt_state    = REQ;
          end else begin
            w_nxt_hold_valid = 1'b1;
            w_nxt_hold_pc    = r_req_pc;
            w_nxt_hold_instr = imem_rdata;
            w_nxt_state      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          w_nxt_if_valid   = 1'b1;
          w_nxt_if_pc      = r_hold_pc;
          w_nxt_if_instr   = r_hold_instr;
          w_nxt_hold_valid = 1'b0;
          w_nxt_state      = REQ;
        end
      end
      DRAIN: begin
        if (imem_rvalid) w_nxt_state = REQ;
      end
      default: w_nxt_state = IDLE;
    endcase

    // Redirect overrides the state actions above; the state choice depends
    // on whether a memory response is still owed.
    if (redirect_valid) begin
      w_nxt_pc         = w_redir_pc;
      w_nxt_if_valid   = 1'b0;
      w_nxt_hold_valid = 1'b0;
      case (r_state)
        IDLE:    w_nxt_state = IDLE;
        REQ:     w_nxt_state = imem_gnt ? DRAIN : REQ;
        WAIT:    w_nxt_state = imem_rvalid ? REQ : DRAIN;
        HOLD:    w_nxt_state = REQ;
        DRAIN:   w_nxt_state = DRAIN;
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_flush;

  assign w_flush = redirect_valid &
                   (r_if_valid | r_hold_valid | (r_state == WAIT) |
                    ((r_state == REQ) & imem_gnt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_flush)   r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  // Performance counters not built.
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory port for the fetch stage.
- Keeps one outstanding request, advances the PC by 4 and presents instr/pc pairs to decode with a stall backpressure.
- Absorbs branch/jump redirects from execute by dropping in-flight and buffered fetches.
- Sits between the PC register path and decode; owns all PC sequencing.

Parameters:
- WORD_WIDTH, 32: width of PC, address and instruction.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  branch/jump taken; has priority over everything else.
- redirect_pc  input  WORD_WIDTH  target; bits [1:0] are ignored and forced to 0.
- stall  input  1  decode cannot accept; output must hold.
- imem_req  output  1  request valid.
- imem_addr  output  WORD_WIDTH  fetch address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; always at least 1 cycle after gnt.
- imem_rdata  input  WORD_WIDTH  instruction.
- if_valid  output  1  if_instr/if_pc valid.
- if_pc  output  WORD_WIDTH  PC of if_instr.
- if_instr  output  WORD_WIDTH  fetched instruction.

Behaviour:
- Reset values: clk and rstn follow the codebase port names; reset is asynchronous and active-low. During reset:
  - pc_q = RESET_PC, state = IDLE, imem_req = 0, imem_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instr = NOP (32'h00000013).
  - Hold buffer is empty.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: entered only from reset. Goes to REQ on the first clock after rstn deasserts.
- REQ:
  - Drives imem_req = 1, imem_addr = pc_q.
  - imem_gnt = 1: latch req_pc = pc_q, go to WAIT.
  - Address is stable while req & ~gnt, unless a redirect occurs.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid, if the output slot is free (~if_valid, or if_valid & ~stall):
    - Load if_instr = imem_rdata, if_pc = req_pc, if_valid = 1.
    - pc_q += 4; go to REQ.
  - On imem_rvalid with the output stalled: store rdata/req_pc in the hold buffer, pc_q += 4, go to HOLD.
- HOLD:
  - No request is issued.
  - When ~stall: move the buffer to the output (if_valid stays 1), go to REQ.
- Consumption: an output beat is consumed at any edge where if_valid & ~stall.
  - If nothing replaces it, if_valid drops to 0 on that edge.
- Fetch-to-output latency: 1 cycle req → gnt (minimum), then rvalid, then if_valid on the next edge. Zero-wait memory gives one instruction every 2 cycles.
- PC arithmetic is modulo 2^WORD_WIDTH: pc_q = 0xFFFFFFFC + 4 wraps to 0.
- Redirect (redirect_valid = 1 at an edge):
  - Applied in every state: pc_q = {redirect_pc[W-1:2], 2'b00}, if_valid = 0, hold buffer cleared.
  - IDLE: stays IDLE, pc_q updated.
  - REQ without gnt: stay in REQ; the new address is driven next cycle.
  - REQ with gnt, or WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - HOLD: go to REQ.
  - DRAIN: stay in DRAIN, pc_q updated.
- DRAIN:
  - imem_req = 0.
  - On imem_rvalid: discard data, go to REQ.
- Simultaneous redirect and stall: redirect wins and the output is invalidated.
- Reset asserted mid-operation: immediate return to reset values. An outstanding memory response arriving later is ignored because state = IDLE.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (+1 per consumed beat) and perf_flush_cnt[31:0] (+1 per redirect that discards a valid output, buffered entry or in-flight request).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg contains:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, DRAIN).
  - NOP_INSTR = 32'h00000013.
  - PC_STEP = 4.
- No sub-module: the hold buffer is a single register pair kept inline.

Test Plan:
- Reset release with gnt tied 1 and rvalid 1 cycle after gnt: addresses 0, 4, 8 are issued. if_pc = 0, 4, 8 with if_valid every other cycle.
- stall held 5 cycles while rvalid returns the instr at pc 8: state goes to HOLD, no imem_req. After stall drops, the output shows pc 4 then 8, in order, none lost.
- Redirect to 0x100 while in WAIT: DRAIN discards the pending rvalid. Next imem_addr = 0x100; if_valid = 0 until the 0x100 data returns.
- redirect_pc = 0x203 in the same cycle as rvalid, with stall = 1: next address is 0x200, if_valid = 0, the returned data is never output.
- pc_q = 0xFFFFFFFC fetched: next imem_addr = 0x00000000.
- rstn asserted during WAIT, rvalid arrives afterwards: outputs are at reset values, the first request after release goes to RESET_PC.
